// File: rtl/tod_pkg.sv
// Shared defaults for the time-of-day counter chain: stage geometry and the
// seconds/minutes/hours stage indices.
package tod_pkg;

  localparam int DEF_WIDTH  = 6;
  localparam int DEF_STAGES = 3;

  // Slice i is the modulus of stage i; stage 0 sits in the low bits.
  localparam logic [DEF_STAGES*DEF_WIDTH-1:0] DEF_MODULI = {6'd24, 6'd60, 6'd60};

  localparam int SEC_IDX  = 0;
  localparam int MIN_IDX  = 1;
  localparam int HOUR_IDX = 2;

endpackage

// File: rtl/mod_stage.sv
// One WIDTH-bit modulo-MOD counter stage with synchronous load.
// A MOD of 0 stands for 2^WIDTH.
module mod_stage #(
  parameter int               WIDTH = 6,
  parameter logic [WIDTH-1:0] MOD   = WIDTH'(60)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             inc,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             at_max
);

  // A zero modulus wraps to all-ones, which is exactly 2^WIDTH - 1.
  localparam logic [WIDTH-1:0] MAX_VAL = MOD - 1'b1;

  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q_reg <= '0;
    end else if (ld) begin
      q_reg <= d;
    end else if (inc) begin
      q_reg <= at_max ? '0 : q_reg + 1'b1;
    end
  end

  assign q      = q_reg;
  assign at_max = (q_reg == MAX_VAL);

endmodule

// File: rtl/tod_counter_chain.sv
// Time-of-day cascade of modulo stages with load validation, deferred ticks
// on load collisions, terminal wrap pulse and an edge-triggered alarm compare.
module tod_counter_chain
  import tod_pkg::*;
#(
  parameter int                        STAGES = DEF_STAGES,
  parameter int                        WIDTH  = DEF_WIDTH,
  parameter logic [STAGES*WIDTH-1:0]   MODULI = DEF_MODULI,
  parameter int                        SELW   = 2
) (
  input  logic                      clk,
  input  logic                      clear_n,
  input  logic                      tick,
  input  logic                      run,
  input  logic                      ld,
  input  logic [SELW-1:0]           ld_sel,
  input  logic [WIDTH-1:0]          ld_data,
  input  logic                      cmp_we,
  input  logic                      alarm_en,
  output logic [STAGES*WIDTH-1:0]   count,
  output logic                      wrap,
  output logic                      alarm,
  output logic                      ld_err,
  output logic                      overrun
);

  logic [STAGES-1:0] at_max;
  logic [STAGES-1:0] stage_wr;
  logic [STAGES-1:0] stage_ld;
  logic [STAGES-1:0] stage_inc;
  logic [STAGES-1:0] eq_next;
  logic [STAGES:0]   low_max;

  logic tick_in, etick, do_tick, wr_ok, match_next;
  logic pend_reg, pend_next;
  logic overrun_reg, overrun_next;
  logic wrap_reg, alarm_reg, ld_err_reg, match_reg;

  assign tick_in    = tick & run;
  assign etick      = tick_in | pend_reg;
  assign do_tick    = etick & ~ld;
  assign low_max[0] = 1'b1;
  assign wr_ok      = |stage_wr;
  assign match_next = &eq_next;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam logic [WIDTH-1:0] MOD_I = MODULI[gi*WIDTH +: WIDTH];
      localparam logic [WIDTH:0]   LIM_I = (MOD_I == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, MOD_I};

      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] cmp_reg;
      logic [WIDTH-1:0] cnt_next;
      logic [WIDTH-1:0] cmp_next;

      assign stage_wr[gi]    = (ld_sel == SELW'(gi)) && ({1'b0, ld_data} < LIM_I);
      assign stage_ld[gi]    = ld & stage_wr[gi];
      assign stage_inc[gi]   = do_tick & low_max[gi];
      assign low_max[gi + 1] = low_max[gi] & at_max[gi];

      mod_stage #(
        .WIDTH (WIDTH),
        .MOD   (MOD_I)
      ) u_stage (
        .clk     (clk),
        .clear_n (clear_n),
        .inc     (stage_inc[gi]),
        .ld      (stage_ld[gi]),
        .d       (ld_data),
        .q       (q),
        .at_max  (at_max[gi])
      );

      assign count[gi*WIDTH +: WIDTH] = q;

      always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
          cmp_reg <= '0;
        end else if (cmp_we && stage_wr[gi]) begin
          cmp_reg <= ld_data;
        end
      end

      // Match is judged on the values this edge will produce, so alarm lines up with count.
      assign cnt_next    = stage_ld[gi]  ? ld_data :
                           stage_inc[gi] ? (at_max[gi] ? '0 : q + 1'b1) : q;
      assign cmp_next    = (cmp_we && stage_wr[gi]) ? ld_data : cmp_reg;
      assign eq_next[gi] = (cnt_next == cmp_next);
    end
  endgenerate

  always_comb begin
    pend_next    = 1'b0;
    overrun_next = overrun_reg;
    if (ld) begin
      pend_next    = etick;
      overrun_next = overrun_reg | (pend_reg & tick_in);
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      pend_reg    <= 1'b0;
      overrun_reg <= 1'b0;
      wrap_reg    <= 1'b0;
      alarm_reg   <= 1'b0;
      ld_err_reg  <= 1'b0;
      match_reg   <= 1'b1;
    end else begin
      pend_reg    <= pend_next;
      overrun_reg <= overrun_next;
      wrap_reg    <= do_tick & low_max[STAGES];
      alarm_reg   <= alarm_en & match_next & ~match_reg;
      ld_err_reg  <= (ld | cmp_we) & ~wr_ok;
      match_reg   <= match_next;
    end
  end

  assign wrap    = wrap_reg;
  assign alarm   = alarm_reg;
  assign ld_err  = ld_err_reg;
  assign overrun = overrun_reg;

endmodule

// File: doc/tod_counter_chain.md
# tod_counter_chain

Parametrised cascade of modulo counters forming the time-of-day core of the digital clock: seconds → minutes → hours by default, generalised to any stage count, width and per-stage modulus. Each stage is loadable from the setting datapath, the chain produces a terminal wrap pulse for the date/calendar logic, and a built-in compare unit replaces the separate timer-compare PLA with a single-cycle alarm pulse. A tick that collides with a load is deferred rather than lost.

## Interface
- `STAGES`, default 3: number of cascaded stages; stage 0 is least significant.
- `WIDTH`, default 6: bits per stage.
- `MODULI`, default {6'd24, 6'd60, 6'd60}: packed `STAGES*WIDTH` vector; stage i modulus is slice i; each slice must be in 2..2^WIDTH (a slice of 0 encodes 2^WIDTH).
- `SELW`, default 2: width of stage select, ≥ clog2(STAGES).

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `clear_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle count request, normally 1 Hz strobe.
- `run` in 1: 1 = ticks counted; 0 = ticks ignored (setting mode).
- `ld` in 1: load strobe for stage `ld_sel`.
- `ld_sel` in SELW: target stage.
- `ld_data` in WIDTH: load value.
- `cmp_we` in 1: write `ld_data` into compare register of stage `ld_sel`.
- `alarm_en` in 1: enables alarm pulse.
- `count` out STAGES*WIDTH: stage values, stage i at slice i.
- `wrap` out 1: one-cycle pulse when every stage wraps together.
- `alarm` out 1: one-cycle pulse on entering compare match.
- `ld_err` out 1: one-cycle pulse on rejected load/compare write.
- `overrun` out 1: sticky; a tick was lost.

## Operation
- Effective tick `etick` = (`tick` & `run`) | `pend`.
- On `etick` with no `ld`: stage 0 increments; stage i increments iff all stages below are at modulus−1; a stage at modulus−1 that increments goes to 0. All stages update in the same edge.
- `wrap` = 1 on the edge where all stages roll to 0.
- `ld` with `ld_sel` < STAGES and `ld_data` < modulus: stage loaded; other stages hold. Otherwise: nothing written, `ld_err` pulses.
- `ld` and `etick` same cycle: load performed, tick deferred: `pend` set; applied next non-`ld` cycle. If `pend` already set and another tick arrives while `ld` still high, `overrun` set (sticky until reset); `pend` stays 1.
- `cmp_we` validated identically; `cmp_we` and `ld` together: both act on `ld_sel`, single `ld_err` if invalid.
- `run` = 0 does not clear `pend`.
- Match = all stages equal their compare registers. `alarm` pulses when match is true on the new count and was false on the previous count, with `alarm_en` = 1. Loading the count into a match also pulses. A match held across many cycles yields one pulse.

## Timing
- Reset: `count` = 0, compare registers = 0, `pend` = 0, `wrap` = 0, `alarm` = 0, `ld_err` = 0, `overrun` = 0. The match history flag resets to 1, so no alarm fires immediately out of reset.
- `count` reflects a tick or load one cycle after the edge sampling it. `wrap`, `ld_err` and `alarm` are registered and aligned with the updated `count`.
- A deferred tick completes one cycle after `ld` drops.
- `clear_n` mid-operation aborts a pending tick; there is no partial update.
- Back-to-back ticks on consecutive cycles are all counted.

## Structure
- Package `tod_pkg`: default `WIDTH`, default `MODULI`, and the seconds/minutes/hours stage-index constants.
- Sub-module `mod_stage`: one WIDTH-bit modulo counter with parameter `MOD` and ports `clk`, `clear_n`, `inc`, `ld`, `d`, `q`, `at_max`. It is instantiated STAGES times by generate, with the carry chain built from `at_max`.
- The top level holds `pend`, `overrun`, the compare registers, the match history and load validation.

## Test plan
All scenarios use the defaults.
- **Reset and count:** reset, `run`=1, 61 ticks → `count` = {0,1,1}; no `wrap`.
- **Full wrap:** load {23,59,59}, 1 tick → `count` = {0,0,0}; `wrap` high exactly one cycle.
- **Invalid load:** `ld` stage 1 with 60 → `ld_err` pulse; stage unchanged. `ld_sel`=3 → `ld_err`.
- **Load/tick collision:** `tick` with `ld` stage 2 = 5 → hours = 5 the next cycle; seconds +1 one cycle after `ld` drops. Two ticks during a 3-cycle `ld` → `overrun` = 1 and stays set.
- **Alarm:** compare = {7,0,0}, `alarm_en`=1, count from {6,59,58} → one `alarm` pulse on entering {7,0,0}; none with `alarm_en`=0.
- **Hold and async reset:** `run`=0 with ticks → `count` frozen. Assert `clear_n` low mid-tick → all outputs 0 asynchronously.
